// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencing, hazard and forwarding controller
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid, id_rs1, id_rs2        ID stage occupancy and source registers
//   ex_opcode, ex_rd, ex_reg_write  EX instruction class and destination
//   ex_rs1, ex_rs2                  EX source registers for forwarding
//   ex_branch_taken                 branch in EX resolved taken
//   mem_opcode, mem_rd, mem_reg_write  MEM instruction class and destination
//   wb_rd, wb_reg_write             WB destination
//   dmem_ready                      data memory completes this cycle
//   halt_req, step_req              debug halt level / single-step pulse
//   pc_en .. mem_wb_en              stage-register enables
//   if_id_flush, id_ex_flush        bubble insertion
//   pc_sel_branch                   PC takes branch target
//   fwd_a, fwd_b                    EX operand select (00 RF, 01 EX/MEM, 10 MEM/WB)
//   halt_ack                        pipeline halted
//   mem_err                         sticky memory-timeout error
//   stall_cnt, flush_cnt            saturating performance counters
module pipeline_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [2:0]        ex_opcode,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              ex_branch_taken,
    input  logic [2:0]        mem_opcode,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              dmem_ready,
    input  logic              halt_req,
    input  logic              step_req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pc_sel_branch,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halt_ack,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_STORE  = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b101;
    localparam int         WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALTED, S_STEP} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              from_step_q, from_step_d;  // freeze began in STEP: return to HALTED
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_access, branch_taken, load_use, advance, stall_inc, flush_inc;
    logic [4:0] en_c;
    logic if_id_flush_c, id_ex_flush_c, pc_sel_c, halt_ack_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign mem_access   = (mem_opcode == OP_LOAD) || (mem_opcode == OP_STORE);
    assign branch_taken = (ex_opcode == OP_BRANCH) && ex_branch_taken;
    assign load_use     = (ex_opcode == OP_LOAD) && ex_reg_write && (ex_rd != '0) && id_valid
                          && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        from_step_d   = from_step_q;
        mem_err_d     = mem_err_q;
        advance       = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        halt_ack_c    = 1'b0;
        en_c          = 5'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        pc_sel_c      = 1'b0;

        case (state_q)
            S_RUN, S_STEP: begin
                if (mem_access && !dmem_ready) begin
                    // Freeze wins over halt; this cycle counts as the first wait cycle.
                    stall_inc   = 1'b1;
                    state_d     = S_MEM_WAIT;
                    wait_d      = WAIT_W'(1);
                    from_step_d = (state_q == S_STEP);
                end else begin
                    advance = 1'b1;
                    if (state_q == S_STEP || halt_req) state_d = S_HALTED;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_ready) begin
                    advance = 1'b1;
                    state_d = from_step_q ? S_HALTED : S_RUN;
                end else begin
                    stall_inc = 1'b1;
                    if (wait_q == WAIT_LIMIT) begin
                        mem_err_d = 1'b1;
                        state_d   = S_HALTED;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: begin  // S_HALTED
                halt_ack_c = 1'b1;
                if (step_req)                     state_d = S_STEP;
                else if (!halt_req && !mem_err_q) state_d = S_RUN;
            end
        endcase

        if (advance) begin
            en_c = 5'b11111;
            if (branch_taken) begin
                pc_sel_c      = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                flush_inc     = 1'b1;
            end else if (load_use) begin
                en_c[4]       = 1'b0;  // pc_en
                en_c[3]       = 1'b0;  // if_id_en
                id_ex_flush_c = 1'b1;
                stall_inc     = 1'b1;
            end
        end

        stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // Nearest producer wins: EX/MEM is younger than MEM/WB.
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1)   fwd_a_c = 2'b01;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1) fwd_a_c = 2'b10;
        if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2)   fwd_b_c = 2'b01;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2) fwd_b_c = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            wait_q      <= '0;
            from_step_q <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            from_step_q <= from_step_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign pc_en         = rst_n & en_c[4];
    assign if_id_en      = rst_n & en_c[3];
    assign id_ex_en      = rst_n & en_c[2];
    assign ex_mem_en     = rst_n & en_c[1];
    assign mem_wb_en     = rst_n & en_c[0];
    assign if_id_flush   = rst_n & if_id_flush_c;
    assign id_ex_flush   = rst_n & id_ex_flush_c;
    assign pc_sel_branch = rst_n & pc_sel_c;
    assign fwd_a         = rst_n ? fwd_a_c : 2'b00;
    assign fwd_b         = rst_n ? fwd_b_c : 2'b00;
    assign halt_ack      = rst_n & halt_ack_c;
    assign mem_err       = mem_err_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic [2:0] ex_opcode, mem_opcode;
    logic       ex_reg_write, ex_branch_taken, mem_reg_write, wb_reg_write;
    logic       dmem_ready, halt_req, step_req;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, pc_sel_branch, halt_ack, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch_taken(ex_branch_taken),
        .mem_opcode(mem_opcode), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .step_req(step_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pc_sel_branch(pc_sel_branch), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halt_ack(halt_ack), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    wire [4:0] en    = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    wire [1:0] flush = {if_id_flush, id_ex_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        ex_opcode = 3'b000; ex_rd = '0; ex_reg_write = 1'b0; ex_rs1 = 5'd5; ex_rs2 = '0;
        ex_branch_taken = 1'b0; mem_opcode = 3'b000; mem_rd = 5'd5; mem_reg_write = 1'b1;
        wb_rd = '0; wb_reg_write = 1'b0; dmem_ready = 1'b1; halt_req = 1'b0; step_req = 1'b0;
        #3;
        check("rst_en", en, 5'b00000);
        check("rst_fwd_a", fwd_a, 2'b00);
        check("rst_halt_ack", halt_ack, 1'b0);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_mem_err", mem_err, 1'b0);
        tick();
        mem_reg_write = 1'b0; ex_rs1 = '0; mem_rd = '0;
        rst_n = 1'b1;
        settle();
        check("run_en", en, 5'b11111);
        check("run_flush", flush, 2'b00);

        // Load-use: one bubble
        ex_opcode = 3'b011; ex_reg_write = 1'b1; ex_rd = 5'd3; id_valid = 1'b1;
        id_rs1 = 5'd1; id_rs2 = 5'd3;
        settle();
        check("lu_en", en, 5'b00111);
        check("lu_flush", flush, 2'b01);
        check("lu_pcsel", pc_sel_branch, 1'b0);
        tick();
        check("lu_stall_cnt", stall_cnt, 1);
        ex_opcode = 3'b000; ex_reg_write = 1'b0;
        settle();
        check("lu_after_en", en, 5'b11111);
        // x0 destination and empty ID never stall
        ex_opcode = 3'b011; ex_reg_write = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        settle();
        check("lu_x0_en", en, 5'b11111);
        ex_rd = 5'd3; id_valid = 1'b0;
        settle();
        check("lu_novalid_en", en, 5'b11111);

        // Branch beats stale load-use match
        id_valid = 1'b1; id_rs1 = 5'd3; ex_opcode = 3'b101; ex_branch_taken = 1'b1;
        settle();
        check("br_pcsel", pc_sel_branch, 1'b1);
        check("br_flush", flush, 2'b11);
        check("br_en", en, 5'b11111);
        tick();
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 1);
        ex_branch_taken = 1'b0;
        settle();
        check("br_nottaken_flush", flush, 2'b00);
        ex_opcode = 3'b000; ex_reg_write = 1'b0; id_valid = 1'b0;

        // Memory wait: 4 frozen cycles, then release
        mem_opcode = 3'b100; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("mw_en_%0d", i), en, 5'b00000);
            check($sformatf("mw_flush_%0d", i), flush, 2'b00);
            tick();
        end
        check("mw_stall_cnt", stall_cnt, 5);
        dmem_ready = 1'b1;
        settle();
        check("mw_release_en", en, 5'b11111);
        tick();
        mem_opcode = 3'b000; dmem_ready = 1'b0;
        settle();
        check("mw_back_run_en", en, 5'b11111);
        check("mw_back_run_ack", halt_ack, 1'b0);

        // Halt / step
        halt_req = 1'b1;
        settle();
        check("hlt_req_cycle_en", en, 5'b11111);
        tick();
        check("hlt_ack", halt_ack, 1'b1);
        check("hlt_en", en, 5'b00000);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        settle();
        check("step_en", en, 5'b11111);
        check("step_ack", halt_ack, 1'b0);
        tick();
        check("step_back_ack", halt_ack, 1'b1);
        check("step_back_en", en, 5'b00000);
        halt_req = 1'b0;
        tick();
        check("resume_ack", halt_ack, 1'b0);
        check("resume_en", en, 5'b11111);
        check("hlt_stall_hold", stall_cnt, 5);

        // Forwarding
        mem_reg_write = 1'b1; mem_rd = 5'd5; wb_reg_write = 1'b1; wb_rd = 5'd5;
        ex_rs1 = 5'd5; ex_rs2 = 5'd5;
        settle();
        check("fwd_a_mem", fwd_a, 2'b01);
        check("fwd_b_mem", fwd_b, 2'b01);
        mem_reg_write = 1'b0;
        settle();
        check("fwd_a_wb", fwd_a, 2'b10);
        mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0;
        settle();
        check("fwd_a_x0", fwd_a, 2'b00);
        wb_rd = 5'd7; ex_rs2 = 5'd7;
        settle();
        check("fwd_b_wb", fwd_b, 2'b10);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // Timeout: 1 freeze cycle + MEM_TIMEOUT wait cycles, then halted with error
        mem_opcode = 3'b011; dmem_ready = 1'b0;
        n = 0;
        while (!halt_ack && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", n, 16);
        check("to_mem_err", mem_err, 1'b1);
        check("to_stall_cnt", stall_cnt, 21);
        tick();
        check("to_stays_halted", halt_ack, 1'b1);
        dmem_ready = 1'b1; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        settle();
        check("to_step_en", en, 5'b11111);
        tick();
        check("to_step_back_ack", halt_ack, 1'b1);
        check("to_err_persist", mem_err, 1'b1);
        rst_n = 1'b0;
        settle();
        check("to_rst_err", mem_err, 1'b0);
        check("to_rst_ack", halt_ack, 1'b0);
        check("to_rst_stall", stall_cnt, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 20-bit, 5-stage (IF/ID/EX/MEM/WB) pipeline. It drives the pipeline-register enables and flushes, resolves load-use and taken-branch hazards, and generates EX operand-forwarding selects. It freezes the pipeline on a multi-cycle data-memory access, with a timeout, and provides a debug halt/single-step handshake. Decoded register fields and opcodes come from the stage registers; the opcode encoding is the ISA's 3-bit field (011 load, 100 store, 101 branch).

## Interface
- REG_AW, default 5: register-address width.
- MEM_TIMEOUT, default 15: maximum MEM_WAIT cycles before error.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- ex_opcode  in  3  EX opcode.
- ex_rd  in  REG_AW  EX destination register.
- ex_reg_write  in  1  EX writes ex_rd.
- ex_rs1, ex_rs2  in  REG_AW  EX source registers (forwarding).
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_opcode  in  3  MEM opcode.
- mem_rd  in  REG_AW  MEM destination register.
- mem_reg_write  in  1  MEM writes mem_rd.
- wb_rd  in  REG_AW  WB destination register.
- wb_reg_write  in  1  WB writes wb_rd.
- dmem_ready  in  1  data memory completes the current access this cycle.
- halt_req  in  1  level request to halt.
- step_req  in  1  single-cycle pulse; one step while halted.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage-register enables.
- if_id_flush, id_ex_flush  out  1  load a bubble into the stage register.
- pc_sel_branch  out  1  PC takes the branch target.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM, 10 MEM/WB.
- halt_ack  out  1  the pipeline is halted.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

## Operation
- The FSM has four states: RUN, MEM_WAIT, HALTED, STEP.
- An "advance cycle" is a cycle in RUN or STEP with no memory freeze, or a MEM_WAIT cycle with dmem_ready=1. In an advance cycle:
  - All enables are 1 by default.
  - Taken branch (ex_opcode=101 and ex_branch_taken): pc_sel_branch=1, if_id_flush=1, id_ex_flush=1, flush_cnt+1.
  - Otherwise, load-use hazard:
    - Condition: ex_opcode=011, ex_reg_write, ex_rd≠0, id_valid, and ex_rd equals id_rs1 or id_rs2.
    - Response: pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt+1.
  - A taken branch has priority over a load-use hazard.
- Memory freeze: in RUN or STEP, when mem_opcode is 011 or 100 and dmem_ready=0:
  - All enables are 0 and no flushes are asserted.
  - stall_cnt+1; next state is MEM_WAIT; the wait counter is set to 1.
- MEM_WAIT:
  - dmem_ready=0: all enables 0, stall_cnt+1, wait counter +1.
  - dmem_ready=1: advance cycle; next state is RUN, or HALTED if the freeze was entered from STEP.
  - dmem_ready=0 with wait counter = MEM_TIMEOUT: mem_err←1, next state is HALTED.
- RUN with halt_req=1: the current cycle still advances normally, then next state is HALTED. A memory freeze takes priority over halt.
- HALTED:
  - All enables 0; halt_ack=1; counters hold.
  - step_req → STEP.
  - halt_req=0 and mem_err=0 → RUN.
  - step_req has priority over leaving HALTED.
- STEP: one advance cycle (or a freeze), then HALTED.
- Forwarding is computed in every state:
  - fwd_a=01 if mem_reg_write, mem_rd≠0, and mem_rd=ex_rs1.
  - Else fwd_a=10 if wb_reg_write, wb_rd≠0, and wb_rd=ex_rs1.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rs2.
- Counters saturate at all-ones and never wrap.
- mem_err is cleared only by reset.

## Timing
- State, wait counter, stall_cnt, flush_cnt and mem_err are registered.
- All other outputs are combinational from the current state and the inputs, with zero latency.
- Reset (rst_n=0):
  - State RUN; counters 0; mem_err 0; halt_ack 0.
  - While rst_n=0: all enables 0, flushes 0, pc_sel_branch 0, fwd 00.
- Reset asserted in any state aborts it immediately and asynchronously.
- Load-use costs exactly 1 bubble. A taken branch costs 2 bubbles.
- Halt latency: halt_ack rises 1 cycle after halt_req is seen in RUN.

## Test plan
- Load-use: EX has opcode 011, rd=3; ID has rs2=3 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1; next cycle all enables 1.
- Branch vs load-use: ex_opcode=101, taken, while ID rs1 matches a (stale) ex_rd → pc_sel_branch=1, both flushes 1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: MEM opcode 100, dmem_ready low for 4 cycles → enables 0 for 4 cycles, stall_cnt=4; 5th cycle enables 1; state RUN.
- Timeout: MEM_TIMEOUT=15, dmem_ready held 0 → mem_err=1 and halt_ack=1; step_req then gives one advance cycle and returns to HALTED; mem_err persists until rst_n pulse.
- Halt/step: halt_req=1 in RUN → halt_ack next cycle; step_req pulse → exactly one cycle with pc_en=1; halt_req=0 → RUN.
- Forwarding: mem_rd=wb_rd=5, both writing, ex_rs1=5 → fwd_a=01; with rd=0 → fwd_a=00.
